// File: rtl/emd_pkg.sv
// Shared constants and encodings for the EMD envelope sequencer.
package emd_pkg;

  localparam int DEPTH = 30;
  localparam int IDX_W = 5;
  localparam int POS_W = 20;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_LINEAR = 2'd1,
    MODE_SPLINE = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_BUSY  = 3'd3,
    ST_CHECK = 3'd4
  } state_e;

endpackage

// File: rtl/emd_envelope_seq_if.sv
// Bundle of the sequencer's control, store and interpolator signals.
interface emd_envelope_seq_if #(
  parameter int IDX_W = emd_pkg::IDX_W,
  parameter int POS_W = emd_pkg::POS_W
);
  logic                    Trg;
  logic                    en;
  logic                    samp_req;
  logic signed [POS_W-1:0] P2;
  logic                    interp_rdy;
  logic                    interp_done;
  logic                    store_we;
  logic [IDX_W-1:0]        wr_idx;
  logic [IDX_W-1:0]        i;
  logic [1:0]              mode;
  logic                    interp_start;
  logic signed [POS_W-1:0] samp_pos;
  logic [IDX_W-1:0]        avail;
  logic                    ovf;

  // The sequencer side
  modport slave (
    input  Trg, en, samp_req, P2, interp_rdy, interp_done,
    output store_we, wr_idx, i, mode, interp_start, samp_pos, avail, ovf
  );

  // The side driving the sequencer
  modport master (
    output Trg, en, samp_req, P2, interp_rdy, interp_done,
    input  store_we, wr_idx, i, mode, interp_start, samp_pos, avail, ovf
  );
endinterface

// File: rtl/emd_ring_ptr.sv
// Write/read pointers of the extrema ring with fill count and overflow flag.
module emd_ring_ptr #(
  parameter int DEPTH = emd_pkg::DEPTH,
  parameter int IDX_W = emd_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trg,
  input  logic             adv,
  output logic [IDX_W-1:0] wr_idx,
  output logic [IDX_W-1:0] rd_idx,
  output logic [IDX_W-1:0] avail,
  output logic [IDX_W-1:0] avail_next,
  output logic             store_we,
  output logic             ovf
);

  logic [IDX_W-1:0] j_reg, j_next;
  logic [IDX_W-1:0] i_reg, i_next;
  logic [IDX_W-1:0] avail_reg;
  logic             ovf_reg;
  logic             full;
  logic [IDX_W:0]   diff;

  function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(DEPTH - 1)) ? '0 : v + IDX_W'(1);
  endfunction

  // Pointer updates and the fill count they imply, one entry kept free
  always_comb begin
    full       = (avail_reg == IDX_W'(DEPTH - 1));
    store_we   = trg & ~full;
    j_next     = store_we ? inc_mod(j_reg) : j_reg;
    i_next     = adv ? inc_mod(i_reg) : i_reg;
    diff       = {1'b0, j_next} + (IDX_W + 1)'(DEPTH) - {1'b0, i_next};
    if (diff >= (IDX_W + 1)'(DEPTH)) begin
      diff = diff - (IDX_W + 1)'(DEPTH);
    end
    avail_next = diff[IDX_W-1:0];
  end

  // Register pointers, count and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      j_reg     <= '0;
      i_reg     <= '0;
      avail_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      j_reg     <= j_next;
      i_reg     <= i_next;
      avail_reg <= avail_next;
      if (trg && full) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  assign wr_idx = j_reg;
  assign rd_idx = i_reg;
  assign avail  = avail_reg;
  assign ovf    = ovf_reg;

endmodule

// File: rtl/emd_envelope_seq.sv
// Sample sequencer for the EMD envelope path: mode select and interpolator handshake.
module emd_envelope_seq
  import emd_pkg::*;
#(
  parameter int DEPTH = emd_pkg::DEPTH,
  parameter int IDX_W = emd_pkg::IDX_W,
  parameter int POS_W = emd_pkg::POS_W
) (
  input  logic               CLK,
  input  logic               RST,
  emd_envelope_seq_if.slave  bus
);

  state_e                  state_reg, state_next;
  mode_e                   mode_reg;
  logic signed [POS_W-1:0] samp_pos_reg;
  logic [IDX_W-1:0]        avail_reg, avail_next;
  logic                    adv;
  logic                    start;

  emd_ring_ptr #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ring_ptr (
    .clk        (CLK),
    .rst        (RST),
    .trg        (bus.Trg),
    .adv        (adv),
    .wr_idx     (bus.wr_idx),
    .rd_idx     (bus.i),
    .avail      (avail_reg),
    .avail_next (avail_next),
    .store_we   (bus.store_we),
    .ovf        (bus.ovf)
  );

  function automatic mode_e mode_of(input logic [IDX_W-1:0] a);
    if (a >= IDX_W'(3)) return MODE_SPLINE;
    if (a == IDX_W'(2)) return MODE_LINEAR;
    return MODE_HOLD;
  endfunction

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next state; en=0 only takes effect between samples
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (bus.en) state_next = ST_WAIT;
      ST_WAIT: begin
        if (!bus.en)                                    state_next = ST_IDLE;
        else if (bus.samp_req && avail_reg != '0)       state_next = ST_ISSUE;
      end
      ST_ISSUE: if (bus.interp_rdy)  state_next = ST_BUSY;
      ST_BUSY:  if (bus.interp_done) state_next = ST_CHECK;
      ST_CHECK: state_next = bus.en ? ST_WAIT : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Start pulse and read-index advance decision
  always_comb begin
    start = (state_reg == ST_ISSUE) && bus.interp_rdy;
    adv   = (state_reg == ST_CHECK) && (samp_pos_reg > bus.P2) &&
            (avail_reg >= IDX_W'(3));
  end

  // Sample position counter and mode, mode frozen while a sample is in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      samp_pos_reg <= '0;
      mode_reg     <= MODE_HOLD;
    end else begin
      if (state_reg == ST_BUSY && bus.interp_done) begin
        samp_pos_reg <= samp_pos_reg + POS_W'(1);
      end
      if (state_reg != ST_ISSUE && state_reg != ST_BUSY) begin
        mode_reg <= mode_of(avail_next);
      end
    end
  end

  assign bus.interp_start = start;
  assign bus.samp_pos     = samp_pos_reg;
  assign bus.mode         = mode_reg;
  assign bus.avail        = avail_reg;

endmodule

// File: tb/tb_emd_envelope_seq.sv
// Randomized self-checking bench for emd_envelope_seq against a ring/count model.
module tb_emd_envelope_seq;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: pointers as plain integers modulo 30
  int m_j, m_i, m_pos, m_ovf, p2_val;

  emd_envelope_seq_if #(.IDX_W(5), .POS_W(20)) bus ();

  emd_envelope_seq dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  function automatic int m_avail();
    return (m_j - m_i + 30) % 30;
  endfunction

  function automatic int m_mode();
    if (m_avail() >= 3) return 2;
    if (m_avail() == 2) return 1;
    return 0;
  endfunction

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_wr_idx"}, bus.wr_idx, m_j);
    check({tag, "_i"}, bus.i, m_i);
    check({tag, "_avail"}, bus.avail, m_avail());
    check({tag, "_mode"}, bus.mode, m_mode());
    check({tag, "_ovf"}, bus.ovf, m_ovf);
    check({tag, "_samp_pos"}, bus.samp_pos, m_pos);
  endtask

  task automatic do_reset();
    bus.Trg = 0; bus.en = 0; bus.samp_req = 0; bus.interp_rdy = 0;
    bus.interp_done = 0; bus.P2 = 0;
    RST = 1;
    step(); step();
    RST = 0;
    m_j = 0; m_i = 0; m_pos = 0; m_ovf = 0;
    check_regs("reset");
    check("reset_start", bus.interp_start, 0);
    check("reset_store_we", bus.store_we, 0);
  endtask

  task automatic pulse_trg();
    bus.Trg = 1;
    #1;
    check("trg_store_we", bus.store_we, (m_avail() != 29) ? 1 : 0);
    if (m_avail() != 29) m_j = (m_j + 1) % 30;
    else                 m_ovf = 1;
    step();
    bus.Trg = 0;
    check_regs("trg");
    $display("trg    j=%0d i=%0d avail=%0d ovf=%0d", bus.wr_idx, bus.i, bus.avail, bus.ovf);
  endtask

  // One full sample transaction starting in WAIT (or IDLE when from_idle)
  task automatic do_sample(input int rdy_wait, input int busy, input bit trg_chk,
                           input bit from_idle);
    int exp_mode;
    bit advance;
    bit wrote;
    exp_mode = m_mode();
    bus.P2 = p2_val;
    bus.en = 1;
    bus.samp_req = 1;
    bus.interp_rdy = (rdy_wait == 0);
    if (from_idle) begin
      step();
      check("lat_first_cycle_start", bus.interp_start, 0);
    end
    step();
    for (int k = 0; k < rdy_wait; k++) begin
      check("issue_wait_start", bus.interp_start, 0);
      check("issue_wait_mode", bus.mode, exp_mode);
      step();
    end
    bus.interp_rdy = 1;
    #1;
    check("issue_start", bus.interp_start, 1);
    check("issue_mode", bus.mode, exp_mode);
    check("issue_i", bus.i, m_i);
    bus.samp_req = 0;
    step();
    check("busy_start", bus.interp_start, 0);
    bus.interp_rdy = 0;
    for (int k = 0; k < busy; k++) begin
      check("busy_mode", bus.mode, exp_mode);
      step();
    end
    bus.interp_done = 1;
    step();
    bus.interp_done = 0;
    m_pos++;
    check("chk_samp_pos", bus.samp_pos, m_pos);
    check("chk_mode_frozen", bus.mode, exp_mode);
    check("chk_i", bus.i, m_i);
    advance = (m_pos > p2_val) && (m_avail() >= 3);
    wrote = 0;
    if (trg_chk) begin
      bus.Trg = 1;
      #1;
      wrote = (m_avail() != 29);
      check("chk_trg_store_we", bus.store_we, wrote ? 1 : 0);
      if (!wrote) m_ovf = 1;
    end
    step();
    bus.Trg = 0;
    if (wrote) m_j = (m_j + 1) % 30;
    if (advance) m_i = (m_i + 1) % 30;
    check_regs("post");
    $display("sample pos=%0d P2=%0d mode=%0d i=%0d j=%0d avail=%0d", bus.samp_pos, p2_val,
             exp_mode, bus.i, bus.wr_idx, bus.avail);
  endtask

  initial begin
    do_reset();

    // Single entry: HOLD, start two cycles after the request from IDLE
    pulse_trg();
    p2_val = 0;
    do_sample(0, 1, 0, 1);
    check("t1_mode_hold", bus.mode, 0);

    // Four entries, P2=3: i advances only once samp_pos reaches 4
    do_reset();
    repeat (4) pulse_trg();
    p2_val = 3;
    bus.en = 1;
    step();
    for (int s = 1; s <= 5; s++) begin
      do_sample(0, $urandom_range(0, 2), 0, 0);
      if (s == 3) check("t2_i_at_pos3", bus.i, 0);
      if (s == 4) begin
        check("t2_i_at_pos4", bus.i, 1);
        check("t2_avail_at_pos4", bus.avail, 3);
      end
    end

    // Fill the ring: 29 accepted, the 30th dropped and ovf sticks
    do_reset();
    repeat (30) pulse_trg();
    check("t3_wr_idx", bus.wr_idx, 29);
    check("t3_avail", bus.avail, 29);
    repeat (3) step();
    check("t3_ovf_sticky", bus.ovf, 1);

    // Walk i to 28 with j=1, then advance and write in the same cycle
    do_reset();
    repeat (3) pulse_trg();
    bus.en = 1;
    step();
    p2_val = -1 - int'($urandom_range(0, 50));
    while (m_i != 28 && n_checks < 20000) begin
      if (m_avail() < 3) pulse_trg();
      do_sample($urandom_range(0, 1), $urandom_range(0, 1), 0, 0);
    end
    pulse_trg();
    check("t4_i_before", bus.i, 28);
    check("t4_j_before", bus.wr_idx, 1);
    do_sample(0, 0, 1, 0);
    check("t4_i_after", bus.i, 29);
    check("t4_j_after", bus.wr_idx, 2);
    check("t4_avail_after", bus.avail, 3);
    check("t4_mode_after", bus.mode, 2);

    // Interpolator not ready for 5 cycles in ISSUE
    p2_val = 1000;
    do_sample(5, 2, 0, 0);

    // Randomized transactions, including empty-ring stalls
    do_reset();
    bus.en = 1;
    step();
    repeat (25) begin
      int ntrg;
      ntrg = $urandom_range(0, 3);
      for (int t = 0; t < ntrg; t++) pulse_trg();
      if (m_avail() == 0) begin
        bus.samp_req = 1;
        repeat (3) begin
          step();
          check("empty_no_start", bus.interp_start, 0);
        end
        bus.samp_req = 0;
        $display("stall  avail=0 no start");
      end else begin
        p2_val = int'($urandom_range(0, m_pos + 3)) - 2;
        do_sample($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
      end
    end

    // Reset while BUSY; the following done must be ignored
    do_reset();
    pulse_trg();
    bus.en = 1; bus.samp_req = 1; bus.interp_rdy = 1;
    step(); step();
    check("t6_start", bus.interp_start, 1);
    bus.samp_req = 0;
    step();
    RST = 1;
    step();
    RST = 0;
    bus.interp_done = 1;
    bus.interp_rdy = 0;
    step();
    bus.interp_done = 0;
    m_j = 0; m_i = 0; m_pos = 0; m_ovf = 0;
    check_regs("t6");
    check("t6_start_after", bus.interp_start, 0);
    $display("rstbusy pos=%0d i=%0d j=%0d", bus.samp_pos, bus.i, bus.wr_idx);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
